// File: rtl/gan_frame_serializer.sv
// gan_frame_serializer: snapshots a flat frame and streams it one bit per cycle over valid/ready.
module gan_frame_serializer #(
    parameter int NUM_PIXELS = 784,
    parameter int PIXEL_W    = 16,
    parameter int RAW_MODE   = 0,
    parameter int THRESHOLD  = 0,
    parameter int CNT_W      = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PIXELS*PIXEL_W-1:0] frame_flat,
    input  logic                          frame_valid,
    output logic                          frame_ready,
    output logic                          pixel_bit,
    output logic                          pixel_bit_valid,
    input  logic                          pixel_bit_ready,
    output logic                          frame_start,
    output logic                          frame_last,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              bit_index
);
    localparam int TOTAL = (RAW_MODE != 0) ? NUM_PIXELS * PIXEL_W : NUM_PIXELS;
    localparam logic signed [PIXEL_W-1:0] THR = PIXEL_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] PW = CNT_W'(PIXEL_W);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                          state_q, state_d;
    logic [NUM_PIXELS*PIXEL_W-1:0]   snap_q, snap_d;
    logic [CNT_W-1:0]                idx_q, idx_d;
    logic                            rdy_q, rdy_d;
    logic [CNT_W-1:0]                pix_sel, bit_sel;
    logic [PIXEL_W-1:0]              pixel, pixel_sh;
    logic                            cur_bit;

    // Raw mode walks each pixel MSB-first; binarised mode sends one compare result per pixel.
    always_comb begin
        pix_sel  = (RAW_MODE != 0) ? idx_q / PW : idx_q;
        bit_sel  = (RAW_MODE != 0) ? idx_q % PW : '0;
        pixel    = PIXEL_W'(snap_q >> (pix_sel * PW));
        pixel_sh = pixel << bit_sel;
        cur_bit  = (RAW_MODE != 0) ? pixel_sh[PIXEL_W-1] : ($signed(pixel) >= THR);
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (frame_valid && rdy_q) begin
                snap_d  = frame_flat;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: if (pixel_bit_ready) begin
                if (idx_q == LAST_IDX) state_d = DONE;
                else idx_d = idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
        end
    end

    assign frame_ready     = rdy_q;
    assign pixel_bit_valid = (state_q == SEND);
    assign pixel_bit       = pixel_bit_valid & cur_bit;
    assign frame_start     = pixel_bit_valid & (idx_q == '0);
    assign frame_last      = pixel_bit_valid & (idx_q == LAST_IDX);
    assign busy            = (state_q == SEND) || (state_q == DONE);
    assign done            = (state_q == DONE);
    assign bit_index       = idx_q;
endmodule

// File: tb/tb_gan_frame_serializer.sv
// tb_gan_frame_serializer: random-frame streaming bench for three configurations of the serializer.
module tb_gan_frame_serializer;
    localparam int N = 784;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic ready = 1'b0;
    logic [N*W-1:0] b_flat = '0;
    logic [4*W-1:0] r_flat = '0;
    logic [3*W-1:0] t_flat = '0;
    logic b_fv = 1'b0, r_fv = 1'b0, t_fv = 1'b0;
    logic b_fr, b_bit, b_v, b_fs, b_fl, b_busy, b_done;
    logic r_fr, r_bit, r_v, r_fs, r_fl, r_busy, r_done;
    logic t_fr, t_bit, t_v, t_fs, t_fl, t_busy, t_done;
    logic [13:0] b_idx;
    logic [6:0]  r_idx;
    logic [5:0]  t_idx;

    gan_frame_serializer u_bin (
        .clk(clk), .rst(rst), .frame_flat(b_flat), .frame_valid(b_fv), .frame_ready(b_fr),
        .pixel_bit(b_bit), .pixel_bit_valid(b_v), .pixel_bit_ready(ready), .frame_start(b_fs),
        .frame_last(b_fl), .busy(b_busy), .done(b_done), .bit_index(b_idx)
    );

    gan_frame_serializer #(.NUM_PIXELS(4), .PIXEL_W(16), .RAW_MODE(1), .THRESHOLD(0), .CNT_W(7)) u_raw (
        .clk(clk), .rst(rst), .frame_flat(r_flat), .frame_valid(r_fv), .frame_ready(r_fr),
        .pixel_bit(r_bit), .pixel_bit_valid(r_v), .pixel_bit_ready(ready), .frame_start(r_fs),
        .frame_last(r_fl), .busy(r_busy), .done(r_done), .bit_index(r_idx)
    );

    gan_frame_serializer #(.NUM_PIXELS(3), .PIXEL_W(16), .RAW_MODE(0), .THRESHOLD(5), .CNT_W(6)) u_thr (
        .clk(clk), .rst(rst), .frame_flat(t_flat), .frame_valid(t_fv), .frame_ready(t_fr),
        .pixel_bit(t_bit), .pixel_bit_valid(t_v), .pixel_bit_ready(ready), .frame_start(t_fs),
        .frame_last(t_fl), .busy(t_busy), .done(t_done), .bit_index(t_idx)
    );

    int sel = 0;
    logic o_fr, o_bit, o_v, o_fs, o_fl, o_busy, o_done;
    logic [13:0] o_idx;
    assign o_fr   = (sel == 0) ? b_fr   : (sel == 1) ? r_fr   : t_fr;
    assign o_bit  = (sel == 0) ? b_bit  : (sel == 1) ? r_bit  : t_bit;
    assign o_v    = (sel == 0) ? b_v    : (sel == 1) ? r_v    : t_v;
    assign o_fs   = (sel == 0) ? b_fs   : (sel == 1) ? r_fs   : t_fs;
    assign o_fl   = (sel == 0) ? b_fl   : (sel == 1) ? r_fl   : t_fl;
    assign o_busy = (sel == 0) ? b_busy : (sel == 1) ? r_busy : t_busy;
    assign o_done = (sel == 0) ? b_done : (sel == 1) ? r_done : t_done;
    assign o_idx  = (sel == 0) ? b_idx  : (sel == 1) ? 14'(r_idx) : 14'(t_idx);

    int n_chk = 0;
    int n_pass = 0;
    int pix[N];
    logic rx[N*W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic set_pix(input int k, input logic [15:0] v);
        pix[k] = int'($signed(v));
    endtask

    function automatic logic exp_bit(input int i);
        if (sel == 1) return logic'((pix[i / W] >> (W - 1 - i % W)) & 1);
        return pix[i] >= ((sel == 2) ? 5 : 0);
    endfunction

    task automatic load_flats();
        for (int k = 0; k < N; k++) b_flat[k*W +: W] = 16'(pix[k]);
        for (int k = 0; k < 4; k++) r_flat[k*W +: W] = 16'(pix[k]);
        for (int k = 0; k < 3; k++) t_flat[k*W +: W] = 16'(pix[k]);
    endtask

    task automatic fv(input logic v);
        b_fv = v && sel == 0;
        r_fv = v && sel == 1;
        t_fv = v && sel == 2;
    endtask

    // rmode: 0 ready always high, 1 toggling, 2 random
    task automatic run_stream(input int rmode, input bit inject, input bit rst_mid);
        int n = 0, cyc = 0, tot, dones = 0;
        bit prev_last = 0, prev_done = 0, flipped = 0;
        tot = (sel == 0) ? N : (sel == 1) ? 4 * W : 3;
        load_flats();
        @(negedge clk);
        check("fr_idle", o_fr, 1);
        fv(1);
        @(negedge clk);
        fv(0);
        check("latency", o_v, 1);
        while (cyc < 5000) begin
            if (rst_mid && n == 100) begin
                rst = 1'b0;
                #1;
                check("rst_valid", o_v, 0);
                check("rst_busy", o_busy, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_done", o_done, 0);
                end
                rst = 1'b1;
                break;
            end
            ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? logic'(cyc % 2 == 0) : logic'($urandom_range(0, 1));
            check("done", o_done, prev_last);
            check("busy", o_busy, (n < tot) || prev_last);
            check("frame_ready", o_fr, prev_done);
            if (prev_done) break;
            check("valid", o_v, n < tot);
            if (o_v) begin
                check("bit", o_bit, exp_bit(n));
                check("bit_index", o_idx, n);
                check("frame_start", o_fs, n == 0);
                check("frame_last", o_fl, n == tot - 1);
                rx[n] = o_bit;
            end
            if (o_done) dones++;
            prev_last = o_v && ready && n == tot - 1;
            prev_done = o_done;
            if (o_v && ready) n++;
            if (inject) begin
                b_fv = n >= 100 && n < 105;
                if (n >= 100 && !flipped) begin
                    b_flat = ~b_flat;
                    flipped = 1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        b_fv = 1'b0;
        if (!rst_mid) begin
            check("transfers", n, tot);
            check("done_pulses", dones, 1);
        end
        check("timeout", cyc < 5000, 1);
    endtask

    initial begin
        logic [15:0] a, b;
        repeat (10) @(negedge clk);
        check("rst_fr", b_fr, 0);
        check("rst_bit", b_bit, 0);
        check("rst_v", b_v, 0);
        check("rst_fs", b_fs, 0);
        check("rst_fl", b_fl, 0);
        check("rst_busy0", b_busy, 0);
        check("rst_done0", b_done, 0);
        check("rst_idx", b_idx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_fr", b_fr, 1);
        check("rel_v", b_v, 0);

        sel = 0;
        for (int k = 0; k < N; k++) set_pix(k, (k % 7 == 0) ? 16'd256 : 16'hFF00);
        run_stream(0, 0, 0);
        run_stream(1, 0, 0);
        for (int k = 0; k < N; k++) set_pix(k, 16'($urandom));
        run_stream(2, 1, 0);
        repeat (20) begin
            @(negedge clk);
            check("idle_v", o_v, 0);
            check("idle_fr", o_fr, 1);
        end
        run_stream(2, 0, 1);
        for (int k = 0; k < N; k++) set_pix(k, 16'($urandom));
        run_stream(2, 0, 0);

        sel = 1;
        set_pix(0, 16'h8001); set_pix(1, 16'h0000); set_pix(2, 16'hFFFF); set_pix(3, 16'h1234);
        run_stream(0, 0, 0);
        for (int j = 0; j < 16; j++) begin
            a[15-j] = rx[j];
            b[15-j] = rx[48+j];
        end
        check("raw_first", a, 16'h8001);
        check("raw_final", b, 16'h1234);
        for (int k = 0; k < 4; k++) set_pix(k, 16'($urandom));
        run_stream(2, 0, 0);

        sel = 2;
        set_pix(0, 16'd5); set_pix(1, 16'd4); set_pix(2, 16'h8000);
        run_stream(1, 0, 0);
        check("thr_eq", rx[0], 1);
        check("thr_below", rx[1], 0);
        check("thr_min", rx[2], 0);
        for (int k = 0; k < 3; k++) set_pix(k, 16'(int'($urandom_range(0, 10))));
        run_stream(2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
